// File: rtl/sm_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : sm_input_debouncer
//  Description : Per-channel pin conditioner: polarity fix, 2-FF synchronizer,
//                counter-based debounce filter and one-cycle edge strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_input_debouncer #(
    parameter int               WIDTH         = 4,
    parameter int               STABLE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] INVERT        = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] INIT          = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rawIn,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] risePulse,
    output logic [WIDTH-1:0] fallPulse
);

    localparam int                c_cnt_w    = $clog2(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Inversion happens ahead of the first flop so the synchronizer and
    // everything downstream only ever see "1 = pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= INIT;
            r_sync2 <= INIT;
        end else begin
            r_sync1 <= rawIn ^ INVERT;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_level;
        logic               r_rise;
        logic               r_fall;

        // Any agreement between the synchronized pin and the accepted level
        // restarts the count, so bounces never accumulate.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_level <= INIT[i];
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (r_sync2[i] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2[i];
                    r_rise  <= r_sync2[i];
                    r_fall  <= ~r_sync2[i];
                end else begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
        end

        assign level[i]     = r_level;
        assign risePulse[i] = r_rise;
        assign fallPulse[i] = r_fall;
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_input_debouncer
//  Description : Scoreboard bench for sm_input_debouncer: directed scenarios
//                followed by randomized bouncing, checked every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_input_debouncer;

    localparam int         WIDTH = 4;
    localparam int         S     = 8;
    localparam logic [3:0] INV   = 4'b0011;
    localparam logic [3:0] INI   = 4'b0000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rawIn = 4'b0011;
    logic [3:0] level;
    logic [3:0] risePulse;
    logic [3:0] fallPulse;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    exp_t sb[$];

    sm_input_debouncer #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(S),
        .INVERT       (INV),
        .INIT         (INI)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rawIn    (rawIn),
        .level    (level),
        .risePulse(risePulse),
        .fallPulse(fallPulse)
    );

    always #5 clk = ~clk;

    // Reference: the filter sees the pin two edges late; a channel accepts
    // the new value on the S-th consecutive edge on which that delayed pin
    // disagrees with the accepted level.
    initial begin : model
        logic [3:0] hist[$];
        logic [3:0] m_lvl;
        logic [3:0] seen;
        logic [3:0] r;
        logic [3:0] f;
        int         since[4];
        int         cyc;
        exp_t       e;
        m_lvl = INI;
        cyc   = 0;
        for (int i = 0; i < 4; i++) since[i] = -1;
        forever begin
            @(posedge clk);
            cyc++;
            r = 4'b0;
            f = 4'b0;
            if (!rst_n) begin
                hist = {INI, INI};
                m_lvl = INI;
                for (int i = 0; i < 4; i++) since[i] = -1;
            end else begin
                seen = hist[0];
                void'(hist.pop_front());
                hist.push_back(rawIn ^ INV);
                for (int i = 0; i < 4; i++) begin
                    if (seen[i] == m_lvl[i]) begin
                        since[i] = -1;
                    end else begin
                        if (since[i] < 0) since[i] = cyc;
                        if (cyc - since[i] + 1 == S) begin
                            m_lvl[i] = seen[i];
                            r[i]     = seen[i];
                            f[i]     = ~seen[i];
                            since[i] = -1;
                        end
                    end
                end
            end
            e = {m_lvl, r, f};
            sb.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty t=%0t: no expected entry for this cycle", $time);
            end else begin
                e = sb.pop_front();
                if ({level, risePulse, fallPulse} !== e) begin
                    fails++;
                    $display("FAIL cycle_check t=%0t got level=%b rise=%b fall=%b need level=%b rise=%b fall=%b",
                             $time, level, risePulse, fallPulse, e.lvl, e.rise, e.fall);
                end
            end
        end
    end

    // Call right after changing inputs on a falling edge: the masked strobe
    // must appear on exactly the 10th rising edge afterwards.
    task automatic wait_pulse(input string name, input logic [3:0] mask,
                              input logic [3:0] exp_rise, input logic [3:0] exp_fall);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (((risePulse | fallPulse) & mask) != 4'b0) hit = 1'b1;
        end
        tests++;
        if (!hit || n != 10 || (risePulse & mask) !== exp_rise || (fallPulse & mask) !== exp_fall) begin
            fails++;
            $display("FAIL %s edges=%0d seen=%0b rise=%b fall=%b need edges=10 rise=%b fall=%b",
                     name, n, hit, risePulse & mask, fallPulse & mask, exp_rise, exp_fall);
        end
    endtask

    initial begin : stimulus
        rst_n = 1'b0;
        rawIn = 4'b0011;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        rawIn = 4'b0111;
        wait_pulse("rise_ch2", 4'b0100, 4'b0100, 4'b0000);
        repeat (5) @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            rawIn[2] = 1'b0;
            repeat (7) @(negedge clk);
            rawIn[2] = 1'b1;
            repeat (10) @(negedge clk);
        end

        for (int k = 0; k < 3; k++) begin
            rawIn[0] = 1'b0;
            repeat (2) @(negedge clk);
            rawIn[0] = 1'b1;
            repeat (2) @(negedge clk);
        end
        rawIn[0] = 1'b0;
        wait_pulse("bounce_ch0", 4'b0001, 4'b0001, 4'b0000);
        repeat (3) @(negedge clk);

        rawIn = 4'b1010;
        wait_pulse("dual_ch3_ch2", 4'b1100, 4'b1000, 4'b0100);
        repeat (3) @(negedge clk);

        rawIn[1] = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_pulse("reset_ch1", 4'b0010, 4'b0010, 4'b0000);

        for (int s = 0; s < 150; s++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end
            rawIn = rawIn ^ 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 14)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
`default_nettype wire
